dbi_rx_cmd_decoder: RTL and testbench
=====================================

# dbi_rx_cmd_decoder

Display-side decoder for the DBI command stream produced by the DBI TX path. It sits behind a DBI RX PHY and consumes one command/data byte per handshake. It decodes hardware reset, soft reset, column and row address set, display-on and memory-write commands. It maintains the address window and emits memory-write data as 16-bit RGB565 pixels tagged with x/y coordinates, for display models, loopback checking and frame capture.

## Interface
- DBI_IF_D_W, 8, command/data byte width
- COORD_W, 16, coordinate width
- DEF_COL_END, 319, column end after reset
- DEF_ROW_END, 239, row end after reset
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- addr_soft_rst_i / addr_disp_on_i / addr_col_i / addr_row_i / addr_mem_wr_i  in  DBI_IF_D_W each  command opcodes, quasi-static
- drp_dbi_hrst_i  in  1  hardware reset seen on the bus (level)
- drp_rx_cmd_typ_i  in  DBI_IF_D_W  opcode of current beat
- drp_rx_cmd_dat_i  in  DBI_IF_D_W  data byte of current beat
- drp_rx_no_dat_i  in  1  command has no data byte
- drp_rx_last_i  in  1  final beat of command
- drp_rx_vld_i  in  1  beat valid
- drp_rx_rdy_o  out  1  beat accepted when vld&rdy
- col_s_o / col_e_o / row_s_o / row_e_o  out  COORD_W each  current window
- disp_on_o  out  1  display enabled
- pxl_d_o  out  16  pixel, first byte in [15:8]
- pxl_x_o / pxl_y_o  out  COORD_W each  pixel coordinate
- pxl_frm_last_o  out  1  pixel is at (col_e,row_e)
- pxl_vld_o  out  1  pixel valid
- pxl_rdy_i  in  1  pixel sink ready
- err_o  out  1  sticky protocol error, cleared by rst, hardware reset or soft reset

## Operation
- Reset values: FSM IDLE; col_s=row_s=0, col_e=DEF_COL_END, row_e=DEF_ROW_END; disp_on_o=0, pxl_vld_o=0, err_o=0, pxl outputs 0.
- The FSM has five states: IDLE, COL, ROW, MEM_WR and DISCARD.
- IDLE decodes the first beat by drp_rx_cmd_typ_i:
  - soft reset (no_dat): window to reset values, disp_on_o=0, err_o=0, stay IDLE.
  - display-on (no_dat): disp_on_o=1.
  - col: go to COL.
  - row: go to ROW.
  - mem-write: go to MEM_WR with x=col_s, y=row_s.
  - any other opcode: err_o=1, then DISCARD unless last.
- COL and ROW: the first beat's data byte is counted as beat 0. Beats 0..3 carry s_h, s_l, e_h, e_l into shadow registers.
  - Commit on beat 3 only if start<=end; otherwise set err_o and keep the old window.
  - last before beat 3: set err_o, no commit, go to IDLE.
  - Beat 3 without last: commit (if valid), set err_o, go to DISCARD.
- MEM_WR: even bytes latch the high half; odd bytes complete a pixel, which is loaded into the output register.
  - After each pixel: x++. If x==col_e, then x=col_s and y++.
  - If additionally y==row_e, then y=row_s and pxl_frm_last_o=1 for that pixel.
  - last on an even byte: the byte is dropped and err_o=1.
  - On last, return to IDLE; the pending output pixel still drains.
- DISCARD: accept beats until last, then go to IDLE.
- drp_dbi_hrst_i high: same effect as soft reset, FSM forced to IDLE, pxl_vld_o cleared, drp_rx_rdy_o=0 while high.
- A new opcode mid-command, i.e. cmd_typ changing before last, is not checked; the beat is treated as data.

## Timing
- drp_rx_rdy_o is combinational:
  - 1 in IDLE, COL, ROW and DISCARD.
  - In MEM_WR: ~pxl_vld_o | pxl_rdy_i.
- Window and disp_on updates are visible the cycle after the committing handshake.
- Pixel latency: pxl_vld_o rises the cycle after the odd-byte handshake. Output is held stable until pxl_rdy_i.
- A simultaneous pixel drain and new odd byte gives back-to-back pixels with no bubble, so full throughput is 1 byte/cycle.
- x/y wrap takes effect in the same cycle as pixel acceptance; no extra cycle.
- rst is asynchronous assert and synchronous-clean deassert by the upstream reset synchronizer.

## Configuration
- DBI_RX_ERR_CNT_EN:
  - Defined: adds output err_cnt_o (16 bit), counting every err_o set event and saturating at 16'hFFFF. It is cleared only by rst.
  - Undefined: port and counter are absent; err_o behaviour is unchanged.

## Structure
- Shared package dbi_pkg holds:
  - state encoding localparams
  - NOP_CMD = 8'h00
  - default window constants
  - RGB565 pixel width (16)
- Sub-module dbi_rx_win_cnt holds the x/y window counter. Inputs: load, advance, col_s/e, row_s/e. Outputs: x, y, frm_last.

## Test plan
- Column set: col beats 00,10,01,3F, then row beats 00,20,00,EF → col_s=0x0010, col_e=0x013F, row_s=0x0020, row_e=0x00EF, err_o=0.
- Memory write: after the window is set to 0..1 × 0..1, mem-write bytes AB,CD,12,34,56,78,9A,BC with pxl_rdy_i=1 →
  - pixels ABCD@(0,0), 1234@(1,0), 5678@(0,1), 9ABC@(1,1)
  - pxl_frm_last_o=1 only on 9ABC
- Backpressure: hold pxl_rdy_i=0 during a pixel stream → drp_rx_rdy_o=0 after the first pixel; pixel data and coordinates stay stable; no byte is lost on release.
- Protocol errors:
  - col command with last on beat 2 → err_o=1, window unchanged.
  - Unknown opcode 0x55 with 3 beats → all 3 accepted, err_o=1, FSM back in IDLE.
- Soft reset and display-on: soft reset after display-on and a modified window → disp_on_o=0, window=0..319 × 0..239, err_o=0.
- Hardware reset mid-stream: pulse drp_dbi_hrst_i during MEM_WR → pxl_vld_o=0 next cycle, FSM IDLE, drp_rx_rdy_o=0 while high.

Source files
------------

// File: rtl/dbi_rx_cmd_decoder_pkg.sv
// Shared constants, window defaults and FSM state encoding for the DBI RX command decoder.
package dbi_pkg;

  localparam int DBI_IF_D_W = 8;
  localparam int COORD_W    = 16;
  localparam int PXL_W      = 16;

  localparam logic [DBI_IF_D_W-1:0] NOP_CMD = 8'h00;

  localparam logic [COORD_W-1:0] DEF_COL_S   = 16'd0;
  localparam logic [COORD_W-1:0] DEF_COL_END = 16'd319;
  localparam logic [COORD_W-1:0] DEF_ROW_S   = 16'd0;
  localparam logic [COORD_W-1:0] DEF_ROW_END = 16'd239;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_COL     = 3'd1;
  localparam logic [2:0] ST_ROW     = 3'd2;
  localparam logic [2:0] ST_MEM_WR  = 3'd3;
  localparam logic [2:0] ST_DISCARD = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_COL     = ST_COL,
    S_ROW     = ST_ROW,
    S_MEM_WR  = ST_MEM_WR,
    S_DISCARD = ST_DISCARD
  } rx_state_e;

endpackage

// File: rtl/dbi_rx_cmd_decoder_if.sv
// Beat stream from the DBI RX PHY and RGB565 pixel stream towards the pixel sink.
interface dbi_rx_cmd_decoder_if;
  import dbi_pkg::*;

  logic                  drp_dbi_hrst_i;
  logic [DBI_IF_D_W-1:0] drp_rx_cmd_typ_i;
  logic [DBI_IF_D_W-1:0] drp_rx_cmd_dat_i;
  logic                  drp_rx_no_dat_i;
  logic                  drp_rx_last_i;
  logic                  drp_rx_vld_i;
  logic                  drp_rx_rdy_o;

  logic [PXL_W-1:0]      pxl_d_o;
  logic [COORD_W-1:0]    pxl_x_o;
  logic [COORD_W-1:0]    pxl_y_o;
  logic                  pxl_frm_last_o;
  logic                  pxl_vld_o;
  logic                  pxl_rdy_i;

  // master is the decoder side, slave is the PHY plus pixel sink side
  modport master (
    input  drp_dbi_hrst_i, drp_rx_cmd_typ_i, drp_rx_cmd_dat_i, drp_rx_no_dat_i,
    input  drp_rx_last_i, drp_rx_vld_i, pxl_rdy_i,
    output drp_rx_rdy_o, pxl_d_o, pxl_x_o, pxl_y_o, pxl_frm_last_o, pxl_vld_o
  );

  modport slave (
    output drp_dbi_hrst_i, drp_rx_cmd_typ_i, drp_rx_cmd_dat_i, drp_rx_no_dat_i,
    output drp_rx_last_i, drp_rx_vld_i, pxl_rdy_i,
    input  drp_rx_rdy_o, pxl_d_o, pxl_x_o, pxl_y_o, pxl_frm_last_o, pxl_vld_o
  );

endinterface

// File: rtl/dbi_rx_win_cnt.sv
// x/y pixel position walker inside the current address window, with end-of-frame flag.
module dbi_rx_win_cnt
  import dbi_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_advance,
  input  logic [COORD_W-1:0] i_col_s,
  input  logic [COORD_W-1:0] i_col_e,
  input  logic [COORD_W-1:0] i_row_s,
  input  logic [COORD_W-1:0] i_row_e,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  output logic               o_frm_last
);

  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic               w_x_wrap;
  logic               w_y_wrap;

  assign w_x_wrap   = (r_x == i_col_e);
  assign w_y_wrap   = (r_y == i_row_e);
  assign o_x        = r_x;
  assign o_y        = r_y;
  assign o_frm_last = w_x_wrap && w_y_wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_load) begin
      r_x <= i_col_s;
      r_y <= i_row_s;
    end else if (i_advance) begin
      if (w_x_wrap) begin
        r_x <= i_col_s;
        r_y <= w_y_wrap ? i_row_s : r_y + COORD_W'(1);
      end else begin
        r_x <= r_x + COORD_W'(1);
      end
    end
  end

endmodule

// File: rtl/dbi_rx_cmd_decoder.sv
// DBI RX command decoder: window registers, display-on, memory-write to RGB565 pixels.
// Optional error event counter output err_cnt_o when DBI_RX_ERR_CNT_EN is defined.
module dbi_rx_cmd_decoder
  import dbi_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DBI_IF_D_W-1:0] addr_soft_rst_i,
  input  logic [DBI_IF_D_W-1:0] addr_disp_on_i,
  input  logic [DBI_IF_D_W-1:0] addr_col_i,
  input  logic [DBI_IF_D_W-1:0] addr_row_i,
  input  logic [DBI_IF_D_W-1:0] addr_mem_wr_i,
  dbi_rx_cmd_decoder_if.master  bus,
  output logic [COORD_W-1:0]    col_s_o,
  output logic [COORD_W-1:0]    col_e_o,
  output logic [COORD_W-1:0]    row_s_o,
  output logic [COORD_W-1:0]    row_e_o,
  output logic                  disp_on_o,
`ifdef DBI_RX_ERR_CNT_EN
  output logic [15:0]           err_cnt_o,
`endif
  output logic                  err_o
);

  rx_state_e             r_state, w_state_nxt;
  logic [1:0]            r_beat, w_beat_nxt;
  logic [DBI_IF_D_W-1:0] r_sh0, r_sh1, r_sh2, r_hi;
  logic                  r_odd, w_odd_nxt;
  logic [COORD_W-1:0]    r_col_s, r_col_e, r_row_s, r_row_e;
  logic                  r_disp_on, r_err;
  logic [PXL_W-1:0]      r_pxl_d;
  logic [COORD_W-1:0]    r_pxl_x, r_pxl_y;
  logic                  r_pxl_last, r_pxl_vld;

  logic                  w_hrst, w_rdy, w_hs, w_last;
  logic [DBI_IF_D_W-1:0] w_typ, w_dat;
  logic [COORD_W-1:0]    w_win_s, w_win_e, w_cnt_x, w_cnt_y;
  logic                  w_win_ok, w_cnt_last;
  logic                  w_sh_we, w_col_we, w_row_we, w_hi_we, w_pxl_load, w_cnt_load;
  logic                  w_err_set, w_soft_rst, w_disp_on_set, w_win_rst;
  logic [1:0]            w_sh_idx;

  assign w_hrst  = bus.drp_dbi_hrst_i;
  assign w_typ   = bus.drp_rx_cmd_typ_i;
  assign w_dat   = bus.drp_rx_cmd_dat_i;
  assign w_last  = bus.drp_rx_last_i;
  assign w_rdy   = w_hrst ? 1'b0 :
                   (r_state == S_MEM_WR) ? (~r_pxl_vld | bus.pxl_rdy_i) : 1'b1;
  assign w_hs    = bus.drp_rx_vld_i && w_rdy;
  assign w_win_s = {r_sh0, r_sh1};
  assign w_win_e = {r_sh2, w_dat};
  assign w_win_ok  = (w_win_s <= w_win_e);
  assign w_sh_idx  = (r_state == S_IDLE) ? 2'd0 : r_beat;
  assign w_win_rst = w_hrst || w_soft_rst;

  // Beat-level decode; every action below is qualified by an accepted handshake.
  always_comb begin
    w_state_nxt   = r_state;
    w_beat_nxt    = r_beat;
    w_odd_nxt     = r_odd;
    w_sh_we       = 1'b0;
    w_col_we      = 1'b0;
    w_row_we      = 1'b0;
    w_hi_we       = 1'b0;
    w_pxl_load    = 1'b0;
    w_cnt_load    = 1'b0;
    w_err_set     = 1'b0;
    w_soft_rst    = 1'b0;
    w_disp_on_set = 1'b0;
    if (w_hs) begin
      unique case (r_state)
        S_IDLE: begin
          w_beat_nxt = 2'd0;
          w_odd_nxt  = 1'b0;
          if (w_typ == addr_soft_rst_i) begin
            w_soft_rst = 1'b1;
            if (!w_last) w_state_nxt = S_DISCARD;
          end else if (w_typ == addr_disp_on_i) begin
            w_disp_on_set = 1'b1;
            if (!w_last) w_state_nxt = S_DISCARD;
          end else if (w_typ == addr_col_i || w_typ == addr_row_i) begin
            if (w_last) begin
              w_err_set = 1'b1;
            end else begin
              w_state_nxt = (w_typ == addr_col_i) ? S_COL : S_ROW;
              if (!bus.drp_rx_no_dat_i) begin
                w_sh_we    = 1'b1;
                w_beat_nxt = 2'd1;
              end
            end
          end else if (w_typ == addr_mem_wr_i) begin
            w_cnt_load = 1'b1;
            if (!bus.drp_rx_no_dat_i) begin
              w_hi_we   = 1'b1;
              w_odd_nxt = 1'b1;
              if (w_last) w_err_set = 1'b1;
            end
            if (!w_last) w_state_nxt = S_MEM_WR;
          end else begin
            w_err_set = 1'b1;
            if (!w_last) w_state_nxt = S_DISCARD;
          end
        end
        S_COL, S_ROW: begin
          if (r_beat == 2'd3) begin
            if (w_win_ok) begin
              w_col_we = (r_state == S_COL);
              w_row_we = (r_state == S_ROW);
            end else begin
              w_err_set = 1'b1;
            end
            if (w_last) begin
              w_state_nxt = S_IDLE;
            end else begin
              w_err_set   = 1'b1;
              w_state_nxt = S_DISCARD;
            end
          end else begin
            w_sh_we    = 1'b1;
            w_beat_nxt = r_beat + 2'd1;
            if (w_last) begin
              w_err_set   = 1'b1;
              w_state_nxt = S_IDLE;
            end
          end
        end
        S_MEM_WR: begin
          if (r_odd) begin
            w_pxl_load = 1'b1;
            w_odd_nxt  = 1'b0;
          end else begin
            w_hi_we   = 1'b1;
            w_odd_nxt = 1'b1;
            if (w_last) w_err_set = 1'b1;
          end
          if (w_last) w_state_nxt = S_IDLE;
        end
        S_DISCARD: begin
          if (w_last) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_beat  <= 2'd0;
      r_odd   <= 1'b0;
    end else if (w_hrst) begin
      r_state <= S_IDLE;
      r_beat  <= 2'd0;
      r_odd   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
      r_odd   <= w_odd_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh0 <= '0;
      r_sh1 <= '0;
      r_sh2 <= '0;
      r_hi  <= '0;
    end else begin
      if (w_sh_we && w_sh_idx == 2'd0) r_sh0 <= w_dat;
      if (w_sh_we && w_sh_idx == 2'd1) r_sh1 <= w_dat;
      if (w_sh_we && w_sh_idx == 2'd2) r_sh2 <= w_dat;
      if (w_hi_we) r_hi <= w_dat;
    end
  end

  // Hardware reset on the bus and soft reset both restore the power-up window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col_s   <= DEF_COL_S;
      r_col_e   <= DEF_COL_END;
      r_row_s   <= DEF_ROW_S;
      r_row_e   <= DEF_ROW_END;
      r_disp_on <= 1'b0;
      r_err     <= 1'b0;
    end else if (w_win_rst) begin
      r_col_s   <= DEF_COL_S;
      r_col_e   <= DEF_COL_END;
      r_row_s   <= DEF_ROW_S;
      r_row_e   <= DEF_ROW_END;
      r_disp_on <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (w_col_we) begin
        r_col_s <= w_win_s;
        r_col_e <= w_win_e;
      end
      if (w_row_we) begin
        r_row_s <= w_win_s;
        r_row_e <= w_win_e;
      end
      if (w_disp_on_set) r_disp_on <= 1'b1;
      if (w_err_set)     r_err     <= 1'b1;
    end
  end

  dbi_rx_win_cnt u_win_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_cnt_load),
    .i_advance  (w_pxl_load),
    .i_col_s    (r_col_s),
    .i_col_e    (r_col_e),
    .i_row_s    (r_row_s),
    .i_row_e    (r_row_e),
    .o_x        (w_cnt_x),
    .o_y        (w_cnt_y),
    .o_frm_last (w_cnt_last)
  );

  // A load only happens when the register is empty or draining, so no pixel is overwritten.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pxl_vld  <= 1'b0;
      r_pxl_d    <= '0;
      r_pxl_x    <= '0;
      r_pxl_y    <= '0;
      r_pxl_last <= 1'b0;
    end else if (w_hrst) begin
      r_pxl_vld  <= 1'b0;
    end else if (w_pxl_load) begin
      r_pxl_vld  <= 1'b1;
      r_pxl_d    <= {r_hi, w_dat};
      r_pxl_x    <= w_cnt_x;
      r_pxl_y    <= w_cnt_y;
      r_pxl_last <= w_cnt_last;
    end else if (bus.pxl_rdy_i) begin
      r_pxl_vld  <= 1'b0;
    end
  end

`ifdef DBI_RX_ERR_CNT_EN
  logic [15:0] r_err_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (w_err_set && r_err_cnt != 16'hFFFF) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign err_cnt_o = r_err_cnt;
`endif

  assign bus.drp_rx_rdy_o   = w_rdy;
  assign bus.pxl_d_o        = r_pxl_d;
  assign bus.pxl_x_o        = r_pxl_x;
  assign bus.pxl_y_o        = r_pxl_y;
  assign bus.pxl_frm_last_o = r_pxl_last;
  assign bus.pxl_vld_o      = r_pxl_vld;
  assign col_s_o            = r_col_s;
  assign col_e_o            = r_col_e;
  assign row_s_o            = r_row_s;
  assign row_e_o            = r_row_e;
  assign disp_on_o          = r_disp_on;
  assign err_o              = r_err;

endmodule

// File: tb/tb_dbi_rx_cmd_decoder.sv
// Directed self-checking bench for dbi_rx_cmd_decoder: window set, pixel stream, backpressure, errors, resets.
module tb_dbi_rx_cmd_decoder;
  import dbi_pkg::*;

  localparam logic [7:0] OP_SRST = 8'h01;
  localparam logic [7:0] OP_DON  = 8'h29;
  localparam logic [7:0] OP_COL  = 8'h2A;
  localparam logic [7:0] OP_ROW  = 8'h2B;
  localparam logic [7:0] OP_MWR  = 8'h2C;

  logic clk;
  logic rst;
  logic [15:0] col_s, col_e, row_s, row_e;
  logic disp_on, err;
`ifdef DBI_RX_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif

  int checks;
  int failures;

  logic [15:0] q_d[$];
  logic [15:0] q_x[$];
  logic [15:0] q_y[$];
  logic        q_l[$];

  dbi_rx_cmd_decoder_if bus ();

  dbi_rx_cmd_decoder dut (
    .clk             (clk),
    .rst             (rst),
    .addr_soft_rst_i (OP_SRST),
    .addr_disp_on_i  (OP_DON),
    .addr_col_i      (OP_COL),
    .addr_row_i      (OP_ROW),
    .addr_mem_wr_i   (OP_MWR),
    .bus             (bus),
    .col_s_o         (col_s),
    .col_e_o         (col_e),
    .row_s_o         (row_s),
    .row_e_o         (row_e),
    .disp_on_o       (disp_on),
`ifdef DBI_RX_ERR_CNT_EN
    .err_cnt_o       (err_cnt),
`endif
    .err_o           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Records every pixel that the sink accepts at the coming rising edge.
  always @(negedge clk) begin
    if (!rst && bus.pxl_vld_o && bus.pxl_rdy_i) begin
      q_d.push_back(bus.pxl_d_o);
      q_x.push_back(bus.pxl_x_o);
      q_y.push_back(bus.pxl_y_o);
      q_l.push_back(bus.pxl_frm_last_o);
    end
  end

  task automatic clear_q();
    q_d.delete();
    q_x.delete();
    q_y.delete();
    q_l.delete();
  endtask

  // Presents one beat and holds it until accepted; returns at posedge+1 with vld dropped.
  task automatic send_beat(input logic [7:0] typ, input logic [7:0] dat,
                           input logic no_dat, input logic last);
    int n;
    n = 0;
    bus.drp_rx_cmd_typ_i = typ;
    bus.drp_rx_cmd_dat_i = dat;
    bus.drp_rx_no_dat_i  = no_dat;
    bus.drp_rx_last_i    = last;
    bus.drp_rx_vld_i     = 1'b1;
    @(negedge clk);
    while (bus.drp_rx_rdy_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("[TB] FAIL beat_timeout typ=%h dat=%h rdy stayed %b", typ, dat, bus.drp_rx_rdy_o);
    end
    @(posedge clk);
    #1;
    bus.drp_rx_vld_i  = 1'b0;
    bus.drp_rx_last_i = 1'b0;
  endtask

  // Bytes are right-justified in data: byte 0 is data[8*(n-1) +: 8].
  task automatic send_cmd(input logic [7:0] typ, input int n, input logic [63:0] data);
    if (n == 0) begin
      send_beat(typ, 8'h00, 1'b1, 1'b1);
    end else begin
      for (int i = 0; i < n; i++) begin
        send_beat(typ, data[8*(n-1-i) +: 8], 1'b0, i == n - 1);
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.drp_dbi_hrst_i   = 1'b0;
    bus.drp_rx_cmd_typ_i = 8'h00;
    bus.drp_rx_cmd_dat_i = 8'h00;
    bus.drp_rx_no_dat_i  = 1'b0;
    bus.drp_rx_last_i    = 1'b0;
    bus.drp_rx_vld_i     = 1'b0;
    bus.pxl_rdy_i        = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (col_s !== 16'd0)   begin failures++; $display("[TB] FAIL rst_col_s got=%h exp=0000", col_s); end
    checks++; if (col_e !== 16'd319) begin failures++; $display("[TB] FAIL rst_col_e got=%h exp=013f", col_e); end
    checks++; if (row_s !== 16'd0)   begin failures++; $display("[TB] FAIL rst_row_s got=%h exp=0000", row_s); end
    checks++; if (row_e !== 16'd239) begin failures++; $display("[TB] FAIL rst_row_e got=%h exp=00ef", row_e); end
    checks++; if (disp_on !== 1'b0 || err !== 1'b0) begin failures++; $display("[TB] FAIL rst_flags got disp_on=%b err=%b exp 0 0", disp_on, err); end
    checks++; if (bus.pxl_vld_o !== 1'b0 || bus.pxl_d_o !== 16'h0000) begin failures++; $display("[TB] FAIL rst_pxl got vld=%b d=%h exp 0 0000", bus.pxl_vld_o, bus.pxl_d_o); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.drp_rx_rdy_o !== 1'b1) begin failures++; $display("[TB] FAIL rst_rdy got=%b exp=1", bus.drp_rx_rdy_o); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_column_set();
    send_cmd(OP_COL, 4, 64'h0010013F);
    send_cmd(OP_ROW, 4, 64'h002000EF);
    checks++; if (col_s !== 16'h0010) begin failures++; $display("[TB] FAIL col_s got=%h exp=0010", col_s); end
    checks++; if (col_e !== 16'h013F) begin failures++; $display("[TB] FAIL col_e got=%h exp=013f", col_e); end
    checks++; if (row_s !== 16'h0020) begin failures++; $display("[TB] FAIL row_s got=%h exp=0020", row_s); end
    checks++; if (row_e !== 16'h00EF) begin failures++; $display("[TB] FAIL row_e got=%h exp=00ef", row_e); end
    checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL win_err got=%b exp=0", err); end
  endtask

  task automatic test_mem_write();
    logic [15:0] exp_d [4] = '{16'hABCD, 16'h1234, 16'h5678, 16'h9ABC};
    logic [15:0] exp_x [4] = '{16'd0, 16'd1, 16'd0, 16'd1};
    logic [15:0] exp_y [4] = '{16'd0, 16'd0, 16'd1, 16'd1};
    logic        exp_l [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    send_cmd(OP_COL, 4, 64'h00000001);
    send_cmd(OP_ROW, 4, 64'h00000001);
    clear_q();
    bus.pxl_rdy_i = 1'b1;
    send_cmd(OP_MWR, 8, 64'hABCD123456789ABC);
    idle_cycles(3);
    checks++; if (q_d.size() != 4) begin failures++; $display("[TB] FAIL mw_count got=%0d exp=4", q_d.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < q_d.size()) begin
        checks++;
        if (q_d[i] !== exp_d[i] || q_x[i] !== exp_x[i] || q_y[i] !== exp_y[i] || q_l[i] !== exp_l[i]) begin
          failures++;
          $display("[TB] FAIL mw_pixel%0d got=%h@(%0d,%0d) last=%b exp=%h@(%0d,%0d) last=%b",
                   i, q_d[i], q_x[i], q_y[i], q_l[i], exp_d[i], exp_x[i], exp_y[i], exp_l[i]);
        end
      end
    end
    checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL mw_err got=%b exp=0", err); end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp_d [3] = '{16'hABCD, 16'h1234, 16'h5678};
    logic [15:0] exp_x [3] = '{16'd0, 16'd1, 16'd0};
    logic [15:0] exp_y [3] = '{16'd0, 16'd0, 16'd1};
    clear_q();
    bus.pxl_rdy_i = 1'b0;
    send_beat(OP_MWR, 8'hAB, 1'b0, 1'b0);
    send_beat(OP_MWR, 8'hCD, 1'b0, 1'b0);
    bus.drp_rx_cmd_dat_i = 8'h12;
    bus.drp_rx_last_i    = 1'b0;
    bus.drp_rx_vld_i     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.drp_rx_rdy_o !== 1'b0 || bus.pxl_vld_o !== 1'b1 || bus.pxl_d_o !== 16'hABCD ||
          bus.pxl_x_o !== 16'd0 || bus.pxl_y_o !== 16'd0) begin
        failures++;
        $display("[TB] FAIL bp_hold%0d got rdy=%b vld=%b d=%h (%0d,%0d) exp rdy=0 vld=1 d=abcd (0,0)",
                 i, bus.drp_rx_rdy_o, bus.pxl_vld_o, bus.pxl_d_o, bus.pxl_x_o, bus.pxl_y_o);
      end
    end
    @(posedge clk);
    #1;
    bus.pxl_rdy_i = 1'b1;
    @(negedge clk);
    checks++; if (bus.drp_rx_rdy_o !== 1'b1) begin failures++; $display("[TB] FAIL bp_release_rdy got=%b exp=1", bus.drp_rx_rdy_o); end
    @(posedge clk);
    #1;
    bus.drp_rx_vld_i = 1'b0;
    send_beat(OP_MWR, 8'h34, 1'b0, 1'b0);
    send_beat(OP_MWR, 8'h56, 1'b0, 1'b0);
    send_beat(OP_MWR, 8'h78, 1'b0, 1'b1);
    idle_cycles(3);
    checks++; if (q_d.size() != 3) begin failures++; $display("[TB] FAIL bp_count got=%0d exp=3", q_d.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < q_d.size()) begin
        checks++;
        if (q_d[i] !== exp_d[i] || q_x[i] !== exp_x[i] || q_y[i] !== exp_y[i]) begin
          failures++;
          $display("[TB] FAIL bp_pixel%0d got=%h@(%0d,%0d) exp=%h@(%0d,%0d)",
                   i, q_d[i], q_x[i], q_y[i], exp_d[i], exp_x[i], exp_y[i]);
        end
      end
    end
  endtask

  task automatic test_protocol_errors();
    send_cmd(OP_COL, 3, 64'h000500);
    checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL short_col_err got=%b exp=1", err); end
    checks++; if (col_s !== 16'd0 || col_e !== 16'd1) begin failures++; $display("[TB] FAIL short_col_win got=%h..%h exp=0000..0001", col_s, col_e); end
    send_cmd(OP_SRST, 0, 64'h0);
    checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL srst_err_clear got=%b exp=0", err); end
    send_cmd(OP_COL, 4, 64'h00200010);
    checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL bad_win_err got=%b exp=1", err); end
    checks++; if (col_s !== 16'd0 || col_e !== 16'd319) begin failures++; $display("[TB] FAIL bad_win_keep got=%h..%h exp=0000..013f", col_s, col_e); end
    send_cmd(OP_SRST, 0, 64'h0);
    clear_q();
    send_cmd(OP_MWR, 3, 64'h112233);
    idle_cycles(2);
    checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL odd_len_err got=%b exp=1", err); end
    checks++;
    if (q_d.size() != 1 || q_d[0] !== 16'h1122 || q_x[0] !== 16'd0 || q_y[0] !== 16'd0) begin
      failures++;
      $display("[TB] FAIL odd_len_pixel got n=%0d d=%h exp n=1 d=1122@(0,0)", q_d.size(), (q_d.size() > 0) ? q_d[0] : 16'h0);
    end
    send_cmd(OP_SRST, 0, 64'h0);
    send_cmd(8'h55, 3, 64'h010203);
    checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL unknown_op_err got=%b exp=1", err); end
    send_cmd(OP_DON, 0, 64'h0);
    checks++; if (disp_on !== 1'b1) begin failures++; $display("[TB] FAIL discard_to_idle disp_on got=%b exp=1", disp_on); end
  endtask

  task automatic test_soft_reset();
    send_cmd(OP_COL, 4, 64'h00100020);
    checks++; if (col_s !== 16'h0010 || col_e !== 16'h0020) begin failures++; $display("[TB] FAIL sr_pre_win got=%h..%h exp=0010..0020", col_s, col_e); end
    send_cmd(OP_SRST, 0, 64'h0);
    checks++; if (disp_on !== 1'b0) begin failures++; $display("[TB] FAIL sr_disp_on got=%b exp=0", disp_on); end
    checks++;
    if (col_s !== 16'd0 || col_e !== 16'd319 || row_s !== 16'd0 || row_e !== 16'd239) begin
      failures++;
      $display("[TB] FAIL sr_window got=%h..%h x %h..%h exp=0000..013f x 0000..00ef", col_s, col_e, row_s, row_e);
    end
    checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL sr_err got=%b exp=0", err); end
  endtask

  task automatic test_hw_reset();
    send_cmd(OP_COL, 4, 64'h00000001);
    send_cmd(OP_ROW, 4, 64'h00000001);
    send_cmd(OP_DON, 0, 64'h0);
    send_cmd(8'h55, 1, 64'h00);
    bus.pxl_rdy_i = 1'b0;
    send_beat(OP_MWR, 8'hAB, 1'b0, 1'b0);
    send_beat(OP_MWR, 8'hCD, 1'b0, 1'b0);
    checks++; if (bus.pxl_vld_o !== 1'b1) begin failures++; $display("[TB] FAIL hr_pre_vld got=%b exp=1", bus.pxl_vld_o); end
    clear_q();
    bus.drp_dbi_hrst_i = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bus.pxl_vld_o !== 1'b0) begin failures++; $display("[TB] FAIL hr_vld got=%b exp=0", bus.pxl_vld_o); end
    @(negedge clk);
    checks++; if (bus.drp_rx_rdy_o !== 1'b0) begin failures++; $display("[TB] FAIL hr_rdy got=%b exp=0", bus.drp_rx_rdy_o); end
    checks++; if (disp_on !== 1'b0 || err !== 1'b0 || col_e !== 16'd319) begin failures++; $display("[TB] FAIL hr_state got disp_on=%b err=%b col_e=%h exp 0 0 013f", disp_on, err, col_e); end
    @(posedge clk);
    #1;
    bus.drp_dbi_hrst_i = 1'b0;
    bus.pxl_rdy_i      = 1'b1;
    send_cmd(OP_ROW, 4, 64'h00030004);
    idle_cycles(2);
    checks++; if (row_s !== 16'd3 || row_e !== 16'd4) begin failures++; $display("[TB] FAIL hr_idle_row got=%h..%h exp=0003..0004", row_s, row_e); end
    checks++; if (q_d.size() != 0) begin failures++; $display("[TB] FAIL hr_no_pixel got n=%0d exp=0", q_d.size()); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_column_set();
    test_mem_write();
    test_backpressure();
    test_protocol_errors();
    test_soft_reset();
    test_hw_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
